// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants, grant FSM encodings and request payload for the data-memory arbiter.
package data_memory_arbiter_pkg;

    localparam int unsigned ADDR_W   = 48;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MEM_AW   = 6;

    localparam logic [0:0] A_PRIO  = 1'b0;
    localparam logic [0:0] B_FORCE = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester-side handshake bundle: one instance per arbiter port.
interface data_memory_arbiter_if;
    import data_memory_arbiter_pkg::*;

    logic              valid;
    req_t              req;
    logic              ready_c;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, output req, input ready_c, input rvalid, input rdata);
    modport slave  (input valid, input req, output ready_c, output rvalid, output rdata);

endinterface

// File: rtl/data_memory_arbiter_starve_counter.sv
// Saturating loss counter for port B; flags the edge on which it reaches MAX.
module data_memory_arbiter_starve_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clear_i,
    output logic reach_c_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign reach_c_o = inc_i && !clear_i && (cnt_q == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port data memory: A has priority,
// B is forced through after MAX_WAIT consecutive losses; reads return one cycle later.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_arbiter_if.slave  a_if,
    data_memory_arbiter_if.slave  b_if,
    output logic                  mem_write_c_o,
    output logic                  mem_read_c_o,
    output logic [ADDR_W-1:0]     mem_addr_c_o,
    output logic [DATA_W-1:0]     mem_wdata_c_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    logic [0:0]        state_q, state_d;
    sel_e              sel_c;
    req_t              req_c;
    logic              reach_c;
    logic              a_rd_c, b_rd_c;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    data_memory_arbiter_starve_counter #(
        .MAX (MAX_WAIT),
        .W   (CNT_W)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (b_if.valid && !b_if.ready_c),
        .clear_i   (!b_if.valid || b_if.ready_c),
        .reach_c_o (reach_c)
    );

    // Grant selection and next-state; nothing is granted while reset is held.
    always_comb begin
        sel_c   = SEL_NONE;
        state_d = state_q;
        case (state_q)
            A_PRIO: begin
                if (a_if.valid)      sel_c = SEL_A;
                else if (b_if.valid) sel_c = SEL_B;
                if (reach_c) state_d = B_FORCE;
            end
            B_FORCE: begin
                if (b_if.valid)      sel_c = SEL_B;
                else if (a_if.valid) sel_c = SEL_A;
                if ((sel_c == SEL_B) || !b_if.valid) state_d = A_PRIO;
            end
            default: state_d = A_PRIO;
        endcase
        if (!rst_n) sel_c = SEL_NONE;
    end

    assign a_if.ready_c = (sel_c == SEL_A);
    assign b_if.ready_c = (sel_c == SEL_B);

    always_comb begin
        req_c = '0;
        case (sel_c)
            SEL_A:   req_c = a_if.req;
            SEL_B:   req_c = b_if.req;
            default: req_c = '0;
        endcase
    end

    assign mem_write_c_o = (sel_c != SEL_NONE) &&  req_c.write;
    assign mem_read_c_o  = (sel_c != SEL_NONE) && !req_c.write;
    assign mem_addr_c_o  = req_c.addr;
    assign mem_wdata_c_o = req_c.wdata;

    assign a_rd_c = (sel_c == SEL_A) && !a_if.req.write;
    assign b_rd_c = (sel_c == SEL_B) && !b_if.req.write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= A_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Read responses: data captured on the grant edge, rvalid pulses the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rd_c;
            b_rvalid_q <= b_rd_c;
            if (a_rd_c) a_rdata_q <= mem_rdata_i;
            if (b_rd_c) b_rdata_q <= mem_rdata_i;
        end
    end

    assign a_if.rvalid = a_rvalid_q;
    assign a_if.rdata  = a_rdata_q;
    assign b_if.rvalid = b_rvalid_q;
    assign b_if.rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter with a behavioural 64-entry data memory behind it.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    typedef struct {
        logic              av, aw;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv, bw;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              ea, eb;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              mem_write, mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [DATA_W-1:0] dmem [64];

    data_memory_arbiter_if a_if ();
    data_memory_arbiter_if b_if ();

    data_memory_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_if          (a_if),
        .b_if          (b_if),
        .mem_write_c_o (mem_write),
        .mem_read_c_o  (mem_read),
        .mem_addr_c_o  (mem_addr),
        .mem_wdata_c_o (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) dmem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = dmem[mem_addr[5:0]];

    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] qa [$];
    logic [DATA_W-1:0] qb [$];
    logic              exp_arv = 1'b0;
    logic              exp_brv = 1'b0;
    vec_t              vecs [$];

    function automatic vec_t mk(logic av, logic aw, logic [ADDR_W-1:0] aa, logic [DATA_W-1:0] ad,
                                logic bv, logic bw, logic [ADDR_W-1:0] ba, logic [DATA_W-1:0] bd,
                                logic ea, logic eb);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        a_if.valid = v.av; a_if.req.write = v.aw; a_if.req.addr = v.aa; a_if.req.wdata = v.ad;
        b_if.valid = v.bv; b_if.req.write = v.bw; b_if.req.addr = v.ba; b_if.req.wdata = v.bd;
    endtask

    // Compare read responses against what the previous cycle's expected grant promised.
    task automatic check_resp();
        logic [DATA_W-1:0] e;
        chk("a_rvalid", 64'(a_if.rvalid), 64'(exp_arv));
        chk("b_rvalid", 64'(b_if.rvalid), 64'(exp_brv));
        if (a_if.rvalid) begin
            if (qa.size() == 0) chk("a_rdata_unexpected", 64'(1), 64'(0));
            else begin e = qa.pop_front(); chk("a_rdata", a_if.rdata, e); end
        end
        if (b_if.rvalid) begin
            if (qb.size() == 0) chk("b_rdata_unexpected", 64'(1), 64'(0));
            else begin e = qb.pop_front(); chk("b_rdata", b_if.rdata, e); end
        end
    endtask

    task automatic step(input vec_t v);
        logic              ew, er;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd;
        @(posedge clk); #1;
        check_resp();
        drive(v);
        #1;
        ew = 1'b0; er = 1'b0; eaddr = '0; ewd = '0;
        if (v.ea) begin ew = v.aw; er = !v.aw; eaddr = v.aa; ewd = v.ad; end
        if (v.eb) begin ew = v.bw; er = !v.bw; eaddr = v.ba; ewd = v.bd; end
        chk("a_ready", 64'(a_if.ready_c), 64'(v.ea));
        chk("b_ready", 64'(b_if.ready_c), 64'(v.eb));
        chk("mem_write", 64'(mem_write), 64'(ew));
        chk("mem_read", 64'(mem_read), 64'(er));
        chk("mem_addr", 64'(mem_addr), 64'(eaddr));
        chk("mem_wdata", mem_wdata, ewd);
        exp_arv = v.ea && !v.aw;
        exp_brv = v.eb && !v.bw;
        if (exp_arv) qa.push_back(ref_mem[v.aa[5:0]]);
        if (exp_brv) qb.push_back(ref_mem[v.ba[5:0]]);
        if (v.ea && v.aw) ref_mem[v.aa[5:0]] = v.ad;
        if (v.eb && v.bw) ref_mem[v.ba[5:0]] = v.bd;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        // Reset and arbitration table
        vecs.push_back(mk(1, 1, 5, 64'hDEAD_BEEF, 1, 1, 20, 64'h2020, 1, 0));
        vecs.push_back(mk(1, 0, 5, 0,             1, 1, 20, 64'h2020, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,             1, 1, 20, 64'h2020, 0, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 0, 5, 0, 1, 0, 20, 0, (i % 5) != 4, (i % 5) == 4));
        vecs.push_back(mk(1, 1, 9, 64'h1, 1, 0, 9, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,     1, 0, 9, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,     1, 1, 134, 64'hCAFE, 0, 1));
        vecs.push_back(mk(1, 0, 70, 0,    0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 9, 0, 1, 0, 5, 0, 1, 0));
        vecs.push_back(mk(1, 0, 9, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 9, 0, 1, 0, 5, 0, 1, 0));
        vecs.push_back(idle);

        rst_n = 1'b0;
        drive(mk(1, 1, 5, 64'h123, 1, 1, 20, 64'h456, 0, 0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_a_rvalid", 64'(a_if.rvalid), 64'(0));
            chk("rst_b_rvalid", 64'(b_if.rvalid), 64'(0));
            chk("rst_mem_write", 64'(mem_write), 64'(0));
        end
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Reset lands while a forced B read is granted: no response may follow.
        for (int i = 0; i < 4; i++) step(mk(1, 0, 5, 0, 1, 0, 20, 0, 1, 0));
        @(posedge clk); #1;
        check_resp();
        drive(mk(1, 0, 5, 0, 1, 0, 20, 0, 0, 1));
        #1;
        chk("force_b_ready", 64'(b_if.ready_c), 64'(1));
        chk("force_a_ready", 64'(a_if.ready_c), 64'(0));
        #2;
        rst_n = 1'b0;
        drive(idle);
        exp_arv = 1'b0;
        exp_brv = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_b_rvalid", 64'(b_if.rvalid), 64'(0));
            chk("midrst_a_rvalid", 64'(a_if.rvalid), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 0, 5, 0, 1, 0, 20, 0, 1, 0));
        step(idle);
        step(idle);
        chk("qa_drained", 64'(qa.size()), 64'(0));
        chk("qb_drained", 64'(qb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
